or8_response_checker: RTL and testbench

//  Receive-side self-check for the 8-input OR gate: consumes each applied input vector

---
 rtl/or8_response_checker.sv | 115 +++++++++++
 tb/tb_or8_response_checker.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/or8_response_checker.sv
// Receive-side checker for the N_IN-input OR gate: compares DUT output to |sample_vec and tracks coverage.
// Optional first-mismatch capture ports are enabled by defining FIRST_FAIL_CAPTURE_EN.
module or8_response_checker #(
  parameter int N_IN = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            sample_valid,
  input  logic [N_IN-1:0] sample_vec,
  input  logic            sample_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN:0]   cov_count
`ifdef FIRST_FAIL_CAPTURE_EN
  ,
  output logic            first_fail_vld,
  output logic [N_IN-1:0] first_fail_vec
`endif
);

  localparam int          N_VEC    = 2 ** N_IN;
  localparam logic [N_IN:0] COV_LAST = {1'b0, {N_IN{1'b1}}};
  localparam logic [N_IN:0] ERR_MAX  = {(N_IN + 1){1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [N_VEC-1:0] bitmap;
  logic             accept;
  logic             mismatch;
  logic             is_new;
  logic             completing;
  logic             restart;

  // start is only meaningful outside RUN; samples only count while RUN
  always_comb begin
    accept     = (state == RUN) && sample_valid;
    restart    = start && (state != RUN);
    mismatch   = sample_out != (|sample_vec);
    is_new     = !bitmap[sample_vec];
    completing = accept && is_new && (cov_count == COV_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (completing) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // pass is decoded from registered state and the registered error count
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
    pass = (state == DONE) && (err_count == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitmap    <= '0;
      err_count <= '0;
      cov_count <= '0;
    end else if (restart) begin
      bitmap    <= '0;
      err_count <= '0;
      cov_count <= '0;
    end else if (accept) begin
      if (mismatch && (err_count != ERR_MAX)) begin
        err_count <= err_count + 1'b1;
      end
      if (is_new) begin
        bitmap[sample_vec] <= 1'b1;
        cov_count          <= cov_count + 1'b1;
      end
    end
  end

`ifdef FIRST_FAIL_CAPTURE_EN
  // only the first mismatch of a run is latched; later ones leave it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
    end else if (restart) begin
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
    end else if (accept && mismatch && !first_fail_vld) begin
      first_fail_vld <= 1'b1;
      first_fail_vec <= sample_vec;
    end
  end
`else
  // no first-mismatch capture in this build
`endif

endmodule

// File: tb/tb_or8_response_checker.sv
// Directed self-checking bench for or8_response_checker.
// Covers full runs, injected mismatches, repeats, ignored samples/starts, async reset and saturation.
module tb_or8_response_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       sample_valid;
  logic [7:0] sample_vec;
  logic       sample_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [8:0] err_count;
  logic [8:0] cov_count;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic       first_fail_vld;
  logic [7:0] first_fail_vec;
`endif

  int checks = 0;
  int errors = 0;

  or8_response_checker #(.N_IN(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .sample_valid (sample_valid),
    .sample_vec   (sample_vec),
    .sample_out   (sample_out),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_count    (err_count),
    .cov_count    (cov_count)
`ifdef FIRST_FAIL_CAPTURE_EN
    ,
    .first_fail_vld (first_fail_vld),
    .first_fail_vec (first_fail_vec)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_or(input logic [7:0] v);
    return |v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] vec, input logic out_val);
    sample_valid = 1'b1;
    sample_vec   = vec;
    sample_out   = out_val;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    sample_valid = 1'b0;
    sample_vec   = '0;
    sample_out   = 1'b0;
    #12;
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_pass", 32'(pass), 0);
    checkOutput("rst_err", 32'(err_count), 0);
    checkOutput("rst_cov", 32'(cov_count), 0);
    do_reset();

    $display("[TB] test 1: full correct run");
    pulse_start();
    checkOutput("t1_busy_after_start", 32'(busy), 1);
    for (int v = 0; v < 255; v++) applyStimulus(8'(v), exp_or(8'(v)));
    checkOutput("t1_cov_255", 32'(cov_count), 255);
    checkOutput("t1_not_done_yet", 32'(done), 0);
    applyStimulus(8'hFF, 1'b1);
    checkOutput("t1_done", 32'(done), 1);
    checkOutput("t1_pass", 32'(pass), 1);
    checkOutput("t1_err", 32'(err_count), 0);
    checkOutput("t1_cov", 32'(cov_count), 256);
    checkOutput("t1_busy", 32'(busy), 0);

    $display("[TB] test 4b: samples after done are ignored");
    applyStimulus(8'h03, 1'b0);
    checkOutput("t4_done_err", 32'(err_count), 0);
    checkOutput("t4_done_cov", 32'(cov_count), 256);
    checkOutput("t4_done_held", 32'(done), 1);

    $display("[TB] test 2: two injected mismatches");
    sample_valid = 1'b1;
    sample_vec   = 8'h00;
    sample_out   = 1'b1;
    pulse_start();
    sample_valid = 1'b0;
    checkOutput("t2_start_cycle_err", 32'(err_count), 0);
    checkOutput("t2_start_cycle_cov", 32'(cov_count), 0);
    checkOutput("t2_pass_cleared", 32'(pass), 0);
    checkOutput("t2_busy", 32'(busy), 1);
    for (int v = 0; v < 256; v++) begin
      if (v == 8'h10 || v == 8'hFF) applyStimulus(8'(v), 1'b0);
      else applyStimulus(8'(v), exp_or(8'(v)));
    end
    checkOutput("t2_done", 32'(done), 1);
    checkOutput("t2_pass", 32'(pass), 0);
    checkOutput("t2_err", 32'(err_count), 2);
`ifdef FIRST_FAIL_CAPTURE_EN
    checkOutput("t2_ff_vld", 32'(first_fail_vld), 1);
    checkOutput("t2_ff_vec", 32'(first_fail_vec), 32'h10);
`endif

    $display("[TB] test 3: repeated vector");
    pulse_start();
    for (int i = 0; i < 3; i++) applyStimulus(8'h05, 1'b1);
    checkOutput("t3_cov_repeat", 32'(cov_count), 1);
    checkOutput("t3_err_repeat", 32'(err_count), 0);
    for (int v = 0; v < 255; v++) begin
      if (v != 5) applyStimulus(8'(v), exp_or(8'(v)));
    end
    checkOutput("t3_cov_255", 32'(cov_count), 255);
    checkOutput("t3_not_done", 32'(done), 0);
    applyStimulus(8'hFF, 1'b1);
    checkOutput("t3_done", 32'(done), 1);
    checkOutput("t3_cov", 32'(cov_count), 256);
    checkOutput("t3_err", 32'(err_count), 0);
    checkOutput("t3_pass", 32'(pass), 1);

    $display("[TB] test 4: idle samples and start in run");
    do_reset();
    applyStimulus(8'h07, 1'b0);
    checkOutput("t4_idle_err", 32'(err_count), 0);
    checkOutput("t4_idle_cov", 32'(cov_count), 0);
    checkOutput("t4_idle_busy", 32'(busy), 0);
    pulse_start();
    for (int v = 0; v < 10; v++) applyStimulus(8'(v), exp_or(8'(v)));
    pulse_start();
    checkOutput("t4_cov_after_start", 32'(cov_count), 10);
    checkOutput("t4_busy_after_start", 32'(busy), 1);
    for (int v = 10; v < 256; v++) applyStimulus(8'(v), exp_or(8'(v)));
    checkOutput("t4_done", 32'(done), 1);
    checkOutput("t4_cov", 32'(cov_count), 256);

    $display("[TB] test 5: async reset mid-run");
    pulse_start();
    for (int v = 0; v < 100; v++) applyStimulus(8'(v), (v == 50) ? 1'b0 : exp_or(8'(v)));
    checkOutput("t5_cov_100", 32'(cov_count), 100);
    checkOutput("t5_err_1", 32'(err_count), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_async_busy", 32'(busy), 0);
    checkOutput("t5_async_err", 32'(err_count), 0);
    checkOutput("t5_async_cov", 32'(cov_count), 0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    for (int v = 0; v < 256; v++) applyStimulus(8'(v), exp_or(8'(v)));
    checkOutput("t5_pass", 32'(pass), 1);
    checkOutput("t5_cov", 32'(cov_count), 256);

    $display("[TB] test 6: error count saturation");
    pulse_start();
    for (int v = 1; v < 256; v++) applyStimulus(8'(v), 1'b0);
    checkOutput("t6_err_255", 32'(err_count), 255);
    for (int v = 1; v < 256; v++) applyStimulus(8'(v), 1'b0);
    checkOutput("t6_err_510", 32'(err_count), 510);
    applyStimulus(8'h01, 1'b0);
    checkOutput("t6_err_511", 32'(err_count), 511);
    for (int v = 2; v < 256; v++) applyStimulus(8'(v), 1'b0);
    checkOutput("t6_err_sat", 32'(err_count), 511);
    checkOutput("t6_cov_255", 32'(cov_count), 255);
    checkOutput("t6_busy", 32'(busy), 1);
    applyStimulus(8'h00, 1'b0);
    checkOutput("t6_done", 32'(done), 1);
    checkOutput("t6_err_final", 32'(err_count), 511);
    checkOutput("t6_pass", 32'(pass), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
